// File: rtl/lsu_stbuf_queue.sv
// Store buffer: DEPTH-entry circular FIFO of committed store words with per-byte DC3 load forwarding.
// Latency: enqueue visible at the head 1 cycle later; forwarding registered, 1 cycle. Backpressure: a store with no free entry is dropped and flagged on stbuf_overflow.
// Optional RV_STBUF_COALESCE_EN merges a store into the youngest entry when the word address matches.

`ifndef RV_DCCM_BITS
`define RV_DCCM_BITS 16
`endif

module lsu_stbuf_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = `RV_DCCM_BITS
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          lsu_freeze_dc3,
    input  logic          st_wr_en_dc3,
    input  logic [AW-1:0] st_addr_dc3,
    input  logic          st_addr_in_pic_dc3,
    input  logic [3:0]    st_byteen_dc3,
    input  logic [31:0]   st_data_dc3,
    output logic          stbuf_reqvld_any,
    output logic [AW-1:0] stbuf_addr_any,
    output logic [31:0]   stbuf_data_any,
    output logic          stbuf_addr_in_pic_any,
    input  logic          lsu_stbuf_commit_any,
    input  logic          ld_fwd_en_dc2,
    input  logic [AW-1:0] ld_addr_lo_dc2,
    input  logic [AW-1:0] ld_addr_hi_dc2,
    output logic [31:0]   stbuf_fwddata_lo_dc3,
    output logic [31:0]   stbuf_fwddata_hi_dc3,
    output logic [3:0]    stbuf_fwdbyteen_lo_dc3,
    output logic [3:0]    stbuf_fwdbyteen_hi_dc3,
    output logic          stbuf_full,
    output logic          stbuf_empty,
    output logic          stbuf_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] pic_q;
    logic [AW-1:2]    addr_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;

    logic commit_fire;
    logic do_coal;
    logic enq;

    assign stbuf_empty      = (count == '0);
    assign stbuf_full       = (count == CNT_FULL);
    assign stbuf_reqvld_any = ~stbuf_empty;
    assign commit_fire      = stbuf_reqvld_any & lsu_stbuf_commit_any;

`ifdef RV_STBUF_COALESCE_EN
    logic [PW-1:0] yng_ptr;
    logic [31:0]   merged_data;

    assign yng_ptr = wr_ptr - PW'(1);
    // Merging into the lone entry while it drains would lose the store, so allocate instead.
    assign do_coal = st_wr_en_dc3 & ~stbuf_empty & ~st_addr_in_pic_dc3 & ~pic_q[yng_ptr]
                   & (addr_q[yng_ptr] == st_addr_dc3[AW-1:2])
                   & ~((count == CNT_ONE) & commit_fire);

    always_comb begin
        merged_data = data_q[yng_ptr];
        for (int b = 0; b < 4; b++) begin
            if (st_byteen_dc3[b]) merged_data[8*b +: 8] = st_data_dc3[8*b +: 8];
        end
    end
`else
    assign do_coal = 1'b0;
`endif

    assign enq            = st_wr_en_dc3 & ~do_coal & (~stbuf_full | commit_fire);
    assign stbuf_overflow = st_wr_en_dc3 & ~do_coal & stbuf_full & ~commit_fire;

    assign stbuf_addr_any        = {addr_q[rd_ptr], 2'b00};
    assign stbuf_data_any        = data_q[rd_ptr];
    assign stbuf_addr_in_pic_any = pic_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld_q  <= '0;
            pic_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                be_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (commit_fire) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            // When full, rd_ptr == wr_ptr; the enqueue write must win over the head invalidate.
            if (enq) begin
                vld_q[wr_ptr]  <= 1'b1;
                pic_q[wr_ptr]  <= st_addr_in_pic_dc3;
                addr_q[wr_ptr] <= st_addr_dc3[AW-1:2];
                be_q[wr_ptr]   <= st_byteen_dc3;
                data_q[wr_ptr] <= st_data_dc3;
                wr_ptr         <= wr_ptr + PW'(1);
            end
`ifdef RV_STBUF_COALESCE_EN
            if (do_coal) begin
                be_q[yng_ptr]   <= be_q[yng_ptr] | st_byteen_dc3;
                data_q[yng_ptr] <= merged_data;
            end
`endif
            case ({enq, commit_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    logic [3:0]  fwd_be_lo;
    logic [3:0]  fwd_be_hi;
    logic [31:0] fwd_data_lo;
    logic [31:0] fwd_data_hi;

    // Walk oldest to youngest so younger matches overwrite older ones byte by byte.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_be_lo   = '0;
        fwd_be_hi   = '0;
        fwd_data_lo = '0;
        fwd_data_hi = '0;
        idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (vld_q[idx] && !pic_q[idx]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_q[idx][b] && (addr_q[idx] == ld_addr_lo_dc2[AW-1:2])) begin
                        fwd_be_lo[b]          = 1'b1;
                        fwd_data_lo[8*b +: 8] = data_q[idx][8*b +: 8];
                    end
                    if (be_q[idx][b] && (addr_q[idx] == ld_addr_hi_dc2[AW-1:2])) begin
                        fwd_be_hi[b]          = 1'b1;
                        fwd_data_hi[8*b +: 8] = data_q[idx][8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            stbuf_fwddata_lo_dc3   <= '0;
            stbuf_fwddata_hi_dc3   <= '0;
            stbuf_fwdbyteen_lo_dc3 <= '0;
            stbuf_fwdbyteen_hi_dc3 <= '0;
        end else if (!lsu_freeze_dc3) begin
            stbuf_fwddata_lo_dc3   <= ld_fwd_en_dc2 ? fwd_data_lo : '0;
            stbuf_fwddata_hi_dc3   <= ld_fwd_en_dc2 ? fwd_data_hi : '0;
            stbuf_fwdbyteen_lo_dc3 <= ld_fwd_en_dc2 ? fwd_be_lo   : '0;
            stbuf_fwdbyteen_hi_dc3 <= ld_fwd_en_dc2 ? fwd_be_hi   : '0;
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{st_addr_dc3[1:0], ld_addr_lo_dc2[1:0], ld_addr_hi_dc2[1:0]};

endmodule

// File: doc/lsu_stbuf_queue.md
# lsu_stbuf_queue

Store buffer between LSU DC3 store commit and the shared DCCM/PIC port arbiter. Buffers up to DEPTH committed store words in a circular FIFO and presents the oldest through the `stbuf_reqvld_any`/`lsu_stbuf_commit_any` handshake. Supplies registered per-byte forwarding data to DC3 loads on the lo and hi banks. Optionally coalesces a new store into the youngest entry when the word address matches.

## Interface
Parameters:
- DEPTH, 4: entry count; power of two, minimum 2.
- AW, `RV_DCCM_BITS`: address width.

Ports:
- clk  in  1  LSU clock.
- rst_l  in  1  reset; asynchronous, active-low.
- lsu_freeze_dc3  in  1  holds the forwarding output flops.
- st_wr_en_dc3  in  1  enqueue request from DC3 store commit.
- st_addr_dc3  in  AW  store byte address; bits [1:0] ignored.
- st_addr_in_pic_dc3  in  1  store targets PIC.
- st_byteen_dc3  in  4  bytes written by this store.
- st_data_dc3  in  32  full merged word.
- stbuf_reqvld_any  out  1  head entry valid.
- stbuf_addr_any  out  AW  head address, [1:0]=0.
- stbuf_data_any  out  32  head data.
- stbuf_addr_in_pic_any  out  1  head targets PIC.
- lsu_stbuf_commit_any  in  1  head accepted by the port this cycle.
- ld_fwd_en_dc2  in  1  load lookup valid.
- ld_addr_lo_dc2  in  AW  load start address.
- ld_addr_hi_dc2  in  AW  load end address.
- stbuf_fwddata_lo_dc3  out  32  forwarded data, lo word.
- stbuf_fwddata_hi_dc3  out  32  forwarded data, hi word.
- stbuf_fwdbyteen_lo_dc3  out  4  forwarded byte enables, lo word.
- stbuf_fwdbyteen_hi_dc3  out  4  forwarded byte enables, hi word.
- stbuf_full  out  1  count==DEPTH.
- stbuf_empty  out  1  count==0.
- stbuf_overflow  out  1  one-cycle pulse when an enqueue is dropped.

## Operation
- **State:** per entry: valid, addr[AW-1:2], in_pic, byteen[3:0], data[31:0]. Also rd_ptr, wr_ptr (log2 DEPTH, wrap modulo DEPTH) and count (log2 DEPTH + 1 bits).
- **Drain:**
  - `stbuf_reqvld_any` = ~empty.
  - Head fields drive the outputs combinationally from the flops.
  - When reqvld & commit: invalidate the head, rd_ptr++, count--.
  - commit while empty is ignored.
- **Enqueue:**
  - When st_wr_en & (~full | commit): write the entry at wr_ptr, wr_ptr++, count++.
  - Simultaneous enqueue and commit leaves count unchanged.
  - Enqueue when full and no commit: store dropped, `stbuf_overflow`=1 for that cycle, no state change.
- **Coalesce** (macro only):
  - Condition: st_wr_en & ~empty & ~st_addr_in_pic_dc3 & ~youngest.in_pic & youngest.addr==st_addr[AW-1:2] & ~(count==1 & commit).
  - Effect: merge into entry wr_ptr-1. For each byte with st_byteen set, overwrite data; youngest.byteen |= st_byteen.
  - No pointer or count change. Overrides the overflow rule, so coalescing is allowed when full.
- **Forwarding:**
  - In DC2, each valid entry is compared against ld_addr_lo[AW-1:2] and ld_addr_hi[AW-1:2]; the PIC bit must match 0.
  - Per byte, the youngest matching entry with byteen set wins.
  - The search covers entries valid at the start of the cycle, including a head committing that cycle. It excludes the same-cycle enqueue.
  - Results register into the *_dc3 outputs. They are zero when ld_fwd_en_dc2=0, and hold when lsu_freeze_dc3=1.
- **Reset:**
  - All valids, pointers and count are 0.
  - reqvld=0, empty=1, full=0, overflow=0.
  - All fwd outputs are 0.
  - addr/data/in_pic outputs are 0.

## Timing
- Enqueue at cycle T into an empty buffer: reqvld=1 at T+1.
- Commit at T: the next entry is at the head at T+1.
- Forward lookup at T: result at T+1; registered output, no combinational in→out path.
- A coalesce at T is visible on forwarding for lookups at T+1 and later.
- Reset asserted mid-operation clears everything asynchronously; buffered stores are lost.

## Configuration
- `RV_STBUF_COALESCE_EN` defined: coalesce logic is present as specified.
- Undefined: every st_wr_en allocates a new entry. The overflow rule applies unconditionally. The youngest-entry compare is removed.

## Test plan
- **Reset/drain:** reset, then enqueue addr 0x100, data 0xAABBCCDD, byteen 0xF. Next cycle reqvld=1 and addr=0x100. Commit → empty=1 the following cycle.
- **Full/overflow:**
  - Enqueue 4 distinct words with commit=0 → full=1.
  - A 5th enqueue → overflow pulse, count stays 4.
  - A 5th enqueue with commit in the same cycle → accepted, count=4, head advances.
- **Wrap:** 10 enqueue/commit pairs, one per cycle, for addrs 0x0..0x24. Head addresses appear in order, no loss, count ≤1.
- **Forwarding priority:**
  - Entries 0x200 {byteen 0x3, data 0x00001111} and younger 0x200 {byteen 0x6, data 0x00222200}; lookup lo=0x200.
  - Macro off: next cycle fwdbyteen_lo=0x7, fwddata_lo[23:0]=0x222211.
  - Macro on: the stores coalesce into one entry, byteen 0x7; forwarding result identical.
- **Coalesce boundary** (macro on):
  - count=1 with commit asserted and a matching store → a new entry is allocated; count stays 1.
  - A matching PIC store → no coalesce.
- **Freeze:** with fwd outputs nonzero, assert lsu_freeze_dc3 and change the lookup. Outputs hold until freeze deasserts.
